// File: rtl/ps2_key_decoder.sv
// Released-key word to ASCII/control-code translator with Caps Lock tracking
// and a first-word-fall-through character FIFO on a valid/ready read port.
module ps2_key_decoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic [15:0] i_ps2_data,
  input  logic        i_key_ready,
  output logic [7:0]  o_key_data,
  output logic        o_key_valid,
  output logic        o_caps,
  output logic        o_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] CAPS_CODE = 16'h0058;

  logic [15:0] cur_q, prev_q;
  logic        key_event;

  logic        map_vld;
  logic        map_letter;
  logic [7:0]  map_char;
  logic        push_vld_q, push_vld_d;
  logic [7:0]  push_data_q, push_data_d;
  logic        caps_q, caps_d;

  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          full, empty, pop, push;
  logic          overflow_q;

  // Input stage: an event is any change to a nonzero word.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= i_ps2_data;
      prev_q <= cur_q;
    end
  end

  assign key_event = (cur_q != prev_q) && (cur_q != '0);

  // Set-2 lookup; arrows only match with the E0 prefix.
  always_comb begin
    map_vld    = 1'b1;
    map_letter = 1'b0;
    map_char   = '0;
    case (cur_q)
      16'h001C: begin map_char = 8'h61; map_letter = 1'b1; end
      16'h0032: begin map_char = 8'h62; map_letter = 1'b1; end
      16'h0021: begin map_char = 8'h63; map_letter = 1'b1; end
      16'h0023: begin map_char = 8'h64; map_letter = 1'b1; end
      16'h0024: begin map_char = 8'h65; map_letter = 1'b1; end
      16'h002B: begin map_char = 8'h66; map_letter = 1'b1; end
      16'h0034: begin map_char = 8'h67; map_letter = 1'b1; end
      16'h0033: begin map_char = 8'h68; map_letter = 1'b1; end
      16'h0043: begin map_char = 8'h69; map_letter = 1'b1; end
      16'h003B: begin map_char = 8'h6A; map_letter = 1'b1; end
      16'h0042: begin map_char = 8'h6B; map_letter = 1'b1; end
      16'h004B: begin map_char = 8'h6C; map_letter = 1'b1; end
      16'h003A: begin map_char = 8'h6D; map_letter = 1'b1; end
      16'h0031: begin map_char = 8'h6E; map_letter = 1'b1; end
      16'h0044: begin map_char = 8'h6F; map_letter = 1'b1; end
      16'h004D: begin map_char = 8'h70; map_letter = 1'b1; end
      16'h0015: begin map_char = 8'h71; map_letter = 1'b1; end
      16'h002D: begin map_char = 8'h72; map_letter = 1'b1; end
      16'h001B: begin map_char = 8'h73; map_letter = 1'b1; end
      16'h002C: begin map_char = 8'h74; map_letter = 1'b1; end
      16'h003C: begin map_char = 8'h75; map_letter = 1'b1; end
      16'h002A: begin map_char = 8'h76; map_letter = 1'b1; end
      16'h001D: begin map_char = 8'h77; map_letter = 1'b1; end
      16'h0022: begin map_char = 8'h78; map_letter = 1'b1; end
      16'h0035: begin map_char = 8'h79; map_letter = 1'b1; end
      16'h001A: begin map_char = 8'h7A; map_letter = 1'b1; end
      16'h0045: map_char = 8'h30;
      16'h0016: map_char = 8'h31;
      16'h001E: map_char = 8'h32;
      16'h0026: map_char = 8'h33;
      16'h0025: map_char = 8'h34;
      16'h002E: map_char = 8'h35;
      16'h0036: map_char = 8'h36;
      16'h003D: map_char = 8'h37;
      16'h003E: map_char = 8'h38;
      16'h0046: map_char = 8'h39;
      16'h0029: map_char = 8'h20;
      16'h005A: map_char = 8'h0D;
      16'h0066: map_char = 8'h08;
      16'hE075: map_char = 8'h80;
      16'hE072: map_char = 8'h81;
      16'hE06B: map_char = 8'h82;
      16'hE074: map_char = 8'h83;
      default:  map_vld  = 1'b0;
    endcase
  end

  always_comb begin
    push_vld_d  = key_event && map_vld;
    push_data_d = (map_letter && caps_q) ? (map_char - 8'h20) : map_char;
    caps_d      = caps_q ^ (key_event && (cur_q == CAPS_CODE));
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      push_vld_q  <= 1'b0;
      push_data_q <= '0;
      caps_q      <= 1'b0;
    end else begin
      push_vld_q  <= push_vld_d;
      push_data_q <= push_data_d;
      caps_q      <= caps_d;
    end
  end

  // FIFO: extra pointer bit distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = o_key_valid && i_key_ready;
  assign push  = push_vld_q && (!full || pop);

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop) rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      if (push_vld_q && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign o_key_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign o_key_valid = !empty;
  assign o_caps      = caps_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: expected characters are queued as keys
// are driven and checked in order as the FIFO is drained.
module tb_ps2_key_decoder;

  logic        CLK_50M;
  logic        RST_N;
  logic [15:0] i_ps2_data;
  logic        i_key_ready;
  logic [7:0]  o_key_data;
  logic        o_key_valid;
  logic        o_caps;
  logic        o_overflow;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  sb [$];

  ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
    .CLK_50M     (CLK_50M),
    .RST_N       (RST_N),
    .i_ps2_data  (i_ps2_data),
    .i_key_ready (i_key_ready),
    .o_key_data  (o_key_data),
    .o_key_valid (o_key_valid),
    .o_caps      (o_caps),
    .o_overflow  (o_overflow)
  );

  initial CLK_50M = 1'b0;
  always #10 CLK_50M = ~CLK_50M;

  task automatic do_reset();
    RST_N = 1'b0; i_ps2_data = '0; i_key_ready = 1'b0;
    sb.delete();
    repeat (2) @(posedge CLK_50M);
    #5 RST_N = 1'b1;
  endtask

  // Drive a word just after an edge and let it reach the FIFO (3 edges + 1).
  task automatic apply(input logic [15:0] w);
    @(posedge CLK_50M); #1 i_ps2_data = w;
    repeat (4) @(posedge CLK_50M);
  endtask

  task automatic pop_check(input string nm);
    int n;
    logic [7:0] exp;
    n = 0;
    @(negedge CLK_50M);
    while (!o_key_valid && n < 10) begin @(negedge CLK_50M); n++; end
    total++;
    if (!o_key_valid) begin
      bad++; $display("FAIL %s: timeout, o_key_valid=%b required 1", nm, o_key_valid);
    end else if (sb.size() == 0) begin
      bad++; $display("FAIL %s: unexpected entry %h, required none", nm, o_key_data);
    end else begin
      exp = sb.pop_front();
      if (o_key_data !== exp) begin
        bad++; $display("FAIL %s: o_key_data=%h required %h", nm, o_key_data, exp);
      end
    end
    i_key_ready = 1'b1;
    @(posedge CLK_50M); #1 i_key_ready = 1'b0;
  endtask

  task automatic check_empty(input string nm);
    @(negedge CLK_50M);
    total++;
    if (o_key_valid !== 1'b0) begin
      bad++; $display("FAIL %s: o_key_valid=%b required 0", nm, o_key_valid);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; i_ps2_data = '0; i_key_ready = 1'b0;
    @(negedge CLK_50M);
    total++;
    if ({o_key_data, o_key_valid, o_caps, o_overflow} !== 11'h000) begin
      bad++; $display("FAIL reset: data=%h valid=%b caps=%b ovf=%b required 00 0 0 0",
                      o_key_data, o_key_valid, o_caps, o_overflow);
    end
  endtask

  task automatic test_basic();
    do_reset();
    @(posedge CLK_50M); #1 i_ps2_data = 16'h001C;
    sb.push_back(8'h61);
    repeat (2) @(posedge CLK_50M);
    @(negedge CLK_50M);
    total++;
    if (o_key_valid !== 1'b0) begin
      bad++; $display("FAIL latency_early: o_key_valid=%b required 0", o_key_valid);
    end
    @(negedge CLK_50M);
    total++;
    if (o_key_valid !== 1'b1) begin
      bad++; $display("FAIL latency_k3: o_key_valid=%b required 1", o_key_valid);
    end
    pop_check("basic_a");
    check_empty("basic_empty");
  endtask

  task automatic test_caps();
    apply(16'h0058);
    @(negedge CLK_50M); total++;
    if (o_caps !== 1'b1) begin bad++; $display("FAIL caps_on: o_caps=%b required 1", o_caps); end
    apply(16'h001C); sb.push_back(8'h41);
    apply(16'h0058);
    @(negedge CLK_50M); total++;
    if (o_caps !== 1'b0) begin bad++; $display("FAIL caps_off: o_caps=%b required 0", o_caps); end
    apply(16'h001C); sb.push_back(8'h61);
    pop_check("caps_A");
    pop_check("caps_a");
    check_empty("caps_empty");
  endtask

  task automatic test_arrows();
    apply(16'h0075);
    apply(16'h0000);
    apply(16'hE075); sb.push_back(8'h80);
    pop_check("arrow_up");
    check_empty("arrow_only_one");
  endtask

  task automatic test_overflow();
    logic [15:0] keys [5];
    logic [7:0]  chars [5];
    keys  = '{16'h0016, 16'h001E, 16'h0026, 16'h0025, 16'h002E};
    chars = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        @(negedge CLK_50M); total++;
        if (o_overflow !== 1'b0) begin
          bad++; $display("FAIL ovf_early: o_overflow=%b required 0", o_overflow);
        end
      end
      apply(keys[i]);
      if (i < 4) sb.push_back(chars[i]);
    end
    @(negedge CLK_50M); total++;
    if (o_overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_set: o_overflow=%b required 1", o_overflow);
    end
    for (int i = 0; i < 4; i++) pop_check("ovf_drain");
    check_empty("ovf_empty");
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp;
    do_reset();
    apply(16'h001C); sb.push_back(8'h61);
    apply(16'h0032); sb.push_back(8'h62);
    apply(16'h0021); sb.push_back(8'h63);
    apply(16'h0023); sb.push_back(8'h64);
    @(posedge CLK_50M); #1 i_ps2_data = 16'h0024;
    repeat (2) @(posedge CLK_50M);
    @(negedge CLK_50M);
    exp = sb.pop_front();
    total++;
    if (o_key_data !== exp || o_key_valid !== 1'b1) begin
      bad++; $display("FAIL full_pop_head: data=%h valid=%b required %h 1", o_key_data, o_key_valid, exp);
    end
    i_key_ready = 1'b1;
    @(posedge CLK_50M); #1 i_key_ready = 1'b0;
    sb.push_back(8'h65);
    @(negedge CLK_50M); total++;
    if (o_overflow !== 1'b0) begin
      bad++; $display("FAIL full_pushpop_ovf: o_overflow=%b required 0", o_overflow);
    end
    for (int i = 0; i < 4; i++) pop_check("full_drain");
    check_empty("full_empty");
  endtask

  task automatic test_async_reset();
    do_reset();
    apply(16'h0058);
    apply(16'h001C); sb.push_back(8'h41);
    apply(16'h0032); sb.push_back(8'h42);
    apply(16'h0021); sb.push_back(8'h43);
    @(posedge CLK_50M);
    #5 RST_N = 1'b0; i_ps2_data = 16'h0024;
    #1 total++;
    if ({o_key_valid, o_caps, o_overflow} !== 3'b000) begin
      bad++; $display("FAIL async_reset: valid=%b caps=%b ovf=%b required 0 0 0",
                      o_key_valid, o_caps, o_overflow);
    end
    sb.delete();
    @(negedge CLK_50M);
    @(posedge CLK_50M);
    #5 RST_N = 1'b1;
    sb.push_back(8'h65);
    pop_check("post_reset_e");
    check_empty("post_reset_empty");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_caps();
    test_arrows();
    test_overflow();
    test_full_pushpop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Downstream consumer of the PS2 frame-decoder's 16-bit released-key word: `{8'hE0|8'h00, scancode}`, which the upstream block holds steady between key releases. The block detects each new released key and translates set-2 scancodes to ASCII or a small set of control codes. It tracks Caps Lock, and buffers the resulting characters in a 4-entry first-word-fall-through FIFO with a valid/ready read port for the display/UART consumer.

## Interface
- FIFO_DEPTH, 4: character FIFO entries; power of two.
- CLK_50M  in  1  system clock, 50 MHz.
- RST_N  in  1  reset, asynchronous, active-low.
- i_ps2_data  in  16  released-key word from the PS2 frame decoder; synchronous to CLK_50M.
- i_key_ready  in  1  consumer accepts the head entry when high with o_key_valid.
- o_key_data  out  8  head-of-FIFO character.
- o_key_valid  out  1  FIFO non-empty.
- o_caps  out  1  Caps Lock state, for the LED.
- o_overflow  out  1  sticky: a translated key was dropped because the FIFO was full.

## Operation
- Input stage:
  - cur <= i_ps2_data and prev <= cur every cycle; both reset to 16'h0000.
  - A key event occurs when cur != prev and cur != 16'h0000.
  - Releasing the same key twice in a row produces one event, because the upstream word does not change.
- Translate stage, registered, combinational lookup on cur:
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Letter case: lower case; upper case (ASCII − 0x20) when caps=1.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - 29 → 0x20, 5A → 0x0D, 66 → 0x08.
  - E075 → 0x80, E072 → 0x81, E06B → 0x82, E074 → 0x83.
  - The E0 prefix is required for arrows. With a 00 prefix, 75/72/6B/74 are unmapped.
  - 00_58 (Caps Lock) toggles caps and is not pushed.
  - All other codes are unmapped and dropped silently, with no flag.
  - Stage outputs: push_data[7:0] and push_vld.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide.
  - Full when the pointer MSBs differ and the low bits are equal. Empty when the pointers are equal.
  - Pop = o_key_valid & i_key_ready.
  - Push = push_vld & (!full | pop).
  - push_vld & full & !pop sets o_overflow. o_overflow clears only on reset.
  - Simultaneous push and pop is legal when full or non-empty; the count is unchanged.
  - Push into an empty FIFO without a pop: o_key_valid rises the following cycle.
  - Pointers wrap modulo 2·FIFO_DEPTH.
- Reset, asynchronous, mid-operation: all state clears immediately.
  - Pointers, cur, prev, push_vld, caps and overflow all go to 0.
  - Queued characters are lost.
  - A nonzero word present on i_ps2_data after reset release counts as a new event.

## Timing
- Reset values: o_key_data 8'h00, o_key_valid 0, o_caps 0, o_overflow 0.
- Latency, with i_ps2_data changing just after edge k:
  - Edge k+1: cur captures the new word, so the event is visible.
  - Edge k+2: push_vld/push_data registered; caps toggles here for 00_58.
  - Edge k+3: written into the FIFO; o_key_valid high after edge k+3 if the FIFO was empty.
- Event throughput: one per cycle is sustained internally. Upstream delivers at most one per PS2 frame, about 1 ms.
- Read port: o_key_data is stable while o_key_valid=1 and i_key_ready=0. The next entry appears the cycle after a pop.
- o_overflow asserts the cycle after the dropped push.

## Test plan
- Reset, then i_ps2_data=0x001C → after 3 edges, o_key_valid=1, o_key_data=0x61. Pulse i_key_ready for 1 cycle → o_key_valid=0.
- Sequence 0x0058, 0x001C, 0x0058, 0x001C with i_key_ready=0:
  - o_caps goes 1, then 0.
  - FIFO holds 0x41; the second 0x001C is not an event (word unchanged from the prior 0x001C? no: prev=0x0058), so the FIFO holds 0x41 then 0x61.
  - Drain → 0x41, 0x61.
- 0x0075 then 0xE075 → only 0x80 queued. 0x0000 in between produces no event.
- i_key_ready=0, apply 5 distinct mapped keys → 4 entries, o_overflow=1. Drain order matches input order.
- FIFO full and i_key_ready=1 in the same cycle a new key arrives → no overflow; count stays 4; the popped value is the oldest entry.
- Assert RST_N low with 3 entries queued and caps=1 → o_key_valid, o_caps and o_overflow are 0 immediately. After release, the held 0x0024 yields 0x65.
